// File: rtl/spram_arbiter.sv
// spram_arbiter: two-requester round-robin arbiter feeding a registered command stage into a
// single-port RAM, returning read data to the issuing requester three cycles after transfer.
module spram_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  in_clock,
   input  logic                  in_reset,
   input  logic                  in_req0_valid,
   input  logic                  in_req0_write,
   input  logic [ADDR_WIDTH-1:0] in_req0_address,
   input  logic [DATA_WIDTH-1:0] in_req0_data,
   output logic                  out_req0_ready,
   output logic                  out_req0_rvalid,
   output logic [DATA_WIDTH-1:0] out_req0_rdata,
   input  logic                  in_req1_valid,
   input  logic                  in_req1_write,
   input  logic [ADDR_WIDTH-1:0] in_req1_address,
   input  logic [DATA_WIDTH-1:0] in_req1_data,
   output logic                  out_req1_ready,
   output logic                  out_req1_rvalid,
   output logic [DATA_WIDTH-1:0] out_req1_rdata,
   output logic                  out_ram_enable,
   output logic                  out_ram_write,
   output logic [ADDR_WIDTH-1:0] out_ram_address,
   output logic [DATA_WIDTH-1:0] out_ram_data,
   input  logic [DATA_WIDTH-1:0] in_ram_data
);
   logic ptr, xfer, gid, rd1_v, rd1_id, rd2_v, rd2_id;
   assign out_req0_ready = ~in_reset & in_req0_valid & (~in_req1_valid | ~ptr);
   assign out_req1_ready = ~in_reset & in_req1_valid & (~in_req0_valid | ptr);
   assign xfer = out_req0_ready | out_req1_ready;
   assign gid  = out_req1_ready;
   // rd1/rd2 track each read (valid + requester id) while the RAM produces its data
   always_ff @(posedge in_clock or posedge in_reset)
      if (in_reset) begin
         ptr             <= 1'b0;
         out_ram_enable  <= 1'b0;
         out_ram_write   <= 1'b0;
         out_ram_address <= '0;
         out_ram_data    <= '0;
         rd1_v           <= 1'b0;
         rd1_id          <= 1'b0;
         rd2_v           <= 1'b0;
         rd2_id          <= 1'b0;
         out_req0_rvalid <= 1'b0;
         out_req1_rvalid <= 1'b0;
         out_req0_rdata  <= '0;
         out_req1_rdata  <= '0;
      end else begin
         out_ram_enable <= xfer;
         if (xfer) begin
            ptr             <= ~gid;
            out_ram_write   <= gid ? in_req1_write : in_req0_write;
            out_ram_address <= gid ? in_req1_address : in_req0_address;
            out_ram_data    <= gid ? in_req1_data : in_req0_data;
         end
         rd1_v           <= xfer & ~(gid ? in_req1_write : in_req0_write);
         rd1_id          <= gid;
         rd2_v           <= rd1_v;
         rd2_id          <= rd1_id;
         out_req0_rvalid <= rd2_v & ~rd2_id;
         out_req1_rvalid <= rd2_v & rd2_id;
         if (rd2_v & ~rd2_id) out_req0_rdata <= in_ram_data;
         if (rd2_v & rd2_id) out_req1_rdata <= in_ram_data;
      end
endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 1024x16 single-port RAM block.
- Accepts read/write commands from two independent requesters over a valid/ready handshake.
- Issues at most one command per cycle to the RAM through a registered command stage.
- Routes read data back to the issuing requester with a fixed latency.

Parameters:
ADDR_WIDTH, 10, RAM address width (RAM depth = 2**ADDR_WIDTH)
DATA_WIDTH, 16, RAM data word width

Ports:
in_clock  input  1  single clock; all state on rising edge
in_reset  input  1  asynchronous, active-high reset
in_req0_valid  input  1  requester 0 command valid
in_req0_write  input  1  requester 0: 1 = write, 0 = read
in_req0_address  input  ADDR_WIDTH  requester 0 address
in_req0_data  input  DATA_WIDTH  requester 0 write data
out_req0_ready  output  1  requester 0 command accepted this cycle
out_req0_rvalid  output  1  requester 0 read data valid (1-cycle pulse per read)
out_req0_rdata  output  DATA_WIDTH  requester 0 read data
in_req1_valid, in_req1_write, in_req1_address, in_req1_data, out_req1_ready, out_req1_rvalid, out_req1_rdata: same as requester 0, for requester 1
out_ram_enable  output  1  to RAM in_enable
out_ram_write  output  1  to RAM in_write
out_ram_address  output  ADDR_WIDTH  to RAM in_address
out_ram_data  output  DATA_WIDTH  to RAM in_data
in_ram_data  input  DATA_WIDTH  from RAM out_data

Behaviour:
- Reset (async, active-high): all out_* registers clear to 0; priority pointer = 0 (requester 0 favoured); read-tracking pipeline cleared. While in_reset = 1, out_reqX_ready = 0. The arbiter does not drive the RAM's own reset.
- Handshake: a command transfers in cycle N when in_reqX_valid & out_reqX_ready. The requester holds valid, write, address and data stable until the transfer. Valid must not be dropped before ready.
- Grant (combinational, from valid and pointer):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester equal to the pointer is granted.
  - Neither valid: no grant.
  - Never both readies high in the same cycle.
- Pointer update: after any transfer, the pointer moves to the non-granted requester. With no transfer, the pointer holds. Result: strict alternation under contention, and a lone requester can transfer every cycle.
- Command stage (registered), cycle N+1: out_ram_enable = 1, with out_ram_write, out_ram_address and out_ram_data equal to the transferred command. With no transfer in N, out_ram_enable = 0 in N+1. The other RAM outputs hold their last values.
- RAM semantics:
  - Write: the RAM updates its memory at the end of N+1. No response to the requester.
  - Read: RAM out_data is valid in N+2.
- Read return:
  - A 2-stage tracking pipeline (valid bit + requester id) follows each read.
  - In_ram_data is captured at the end of N+2 into out_reqX_rdata of the issuing requester.
  - out_reqX_rvalid = 1 for exactly cycle N+3.
  - Read latency = 3 cycles from transfer to rvalid.
- out_reqX_rdata holds its last value when rvalid = 0. The other requester's rdata is not disturbed.
- Throughput: 1 command per cycle total. Reads retire in issue order.
- Read-after-write, same address, consecutive transfers: the read returns the new data (the write completes in the RAM before the read is sampled).
- Addresses pass through unmodified. The full range 0 to 2**ADDR_WIDTH-1 is legal, with no wrap logic.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. A command issued to the RAM in the reset cycle is dropped (out_ram_enable forced to 0).

Test Plan:
- Write/read, req0 alone: write addr 0x005 data 0xBEEF, then read 0x005 -> out_req0_rvalid pulses 3 cycles after the read transfer with out_req0_rdata = 0xBEEF; out_req1_rvalid stays 0.
- Contention: both valid for 4 consecutive reads (req0 addrs 0x010,0x011; req1 addrs 0x020,0x021, preloaded 0xA0A0, 0xA1A1, 0xB0B0, 0xB1B1) -> grants alternate 0,1,0,1; each requester gets its own data in order, 3 cycles after its transfer.
- Back-to-back: req1 alone issues 8 reads of 0x3F8..0x3FF -> ready high for 8 consecutive cycles; rvalid high for 8 consecutive cycles with matching data.
- Read-after-write: req0 writes 0x100 = 0x1234 and the next cycle reads 0x100 -> rdata = 0x1234.
- Reset mid-flight: assert in_reset 1 cycle after a read transfer -> no rvalid for that read; all outputs 0; after release, a contended first transfer goes to req0.
- Idle: no valid for 10 cycles -> out_ram_enable = 0 and no rvalid throughout; the pointer is unchanged.
